// File: rtl/divider_pkg.sv
// Shared definitions for the iterative divider: FSM encodings, iteration
// counts, and the output sign/width fix-up used when a result is produced.
package divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [6:0] ITER_D = 7'd64;
  localparam logic [6:0] ITER_W = 7'd32;

  // Sign-extend bit 31 for word ops; full 64-bit value otherwise.
  function automatic logic [63:0] sext_w(input logic [63:0] x, input logic w);
    return w ? {{32{x[31]}}, x[31:0]} : x;
  endfunction

  // Apply the latched sign to an unsigned magnitude, then the word extension.
  function automatic logic [63:0] fix_result(input logic [63:0] mag,
                                             input logic neg, input logic w);
    logic [63:0] v;
    v = neg ? (64'd0 - mag) : mag;
    return sext_w(v, w);
  endfunction

endpackage

// File: rtl/divider.sv
// Radix-2 restoring divider, one quotient bit per cycle (64 or 32 cycles),
// with early exit for divide-by-zero and signed overflow.
module divider
  import divider_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        div_valid,
  output logic        div_ready,
  input  logic        divw,
  input  logic        div_signed,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] quotient,
  output logic [63:0] remainder
);

  state_t       state, state_nxt;
  logic [127:0] rem_q;
  logic [63:0]  dvsr;
  logic [6:0]   cnt;
  logic         w_q, q_neg, r_neg;

  logic         accept, a_sign, b_sign, div_zero, ovf, last;
  logic [63:0]  a_ext, b_ext, a_neg, b_neg, a_abs, b_abs;
  logic [64:0]  diff;
  logic [127:0] rem_nxt;

  assign div_ready = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = div_valid & div_ready;

  // Operand decode at accept time, restricted to the selected width.
  assign a_ext  = divw ? {32'd0, dividend[31:0]} : dividend;
  assign b_ext  = divw ? {32'd0, divisor[31:0]}  : divisor;
  assign a_sign = div_signed & (divw ? dividend[31] : dividend[63]);
  assign b_sign = div_signed & (divw ? divisor[31]  : divisor[63]);
  assign a_neg  = 64'd0 - a_ext;
  assign b_neg  = 64'd0 - b_ext;
  assign a_abs  = a_sign ? (divw ? {32'd0, a_neg[31:0]} : a_neg) : a_ext;
  assign b_abs  = b_sign ? (divw ? {32'd0, b_neg[31:0]} : b_neg) : b_ext;

  assign div_zero = (b_ext == 64'd0);
  assign ovf = div_signed &
               (divw ? (dividend[31:0] == 32'h8000_0000 && divisor[31:0] == 32'hFFFF_FFFF)
                     : (dividend == 64'h8000_0000_0000_0000 && divisor == '1));

  // Top 65 bits of the shifted partial remainder against the divisor; the
  // borrow bit decides whether the subtraction is kept.
  assign diff    = rem_q[127:63] - {1'b0, dvsr};
  assign rem_nxt = diff[64] ? {rem_q[126:0], 1'b0}
                            : {diff[63:0], rem_q[62:0], 1'b1};
  assign last    = (cnt == ((w_q ? ITER_W : ITER_D) - 7'd1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = (div_zero | ovf) ? S_DONE : S_BUSY;
      S_BUSY: if (last) state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q     <= '0;
      dvsr      <= '0;
      cnt       <= '0;
      w_q       <= 1'b0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          // Word ops park the dividend in the upper half of the low word so
          // 32 shifts leave the quotient right-aligned.
          rem_q <= divw ? {64'd0, a_abs[31:0], 32'd0} : {64'd0, a_abs};
          dvsr  <= b_abs;
          w_q   <= divw;
          q_neg <= a_sign ^ b_sign;
          r_neg <= a_sign;
          cnt   <= '0;
          if (div_zero) begin
            quotient  <= '1;
            remainder <= sext_w(dividend, divw);
          end else if (ovf) begin
            quotient  <= sext_w(dividend, divw);
            remainder <= '0;
          end
        end
        S_BUSY: begin
          rem_q <= rem_nxt;
          cnt   <= cnt + 7'd1;
          if (last) begin
            quotient  <= fix_result(rem_nxt[63:0],   q_neg, w_q);
            remainder <= fix_result(rem_nxt[127:64], r_neg, w_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: scoreboard of expected results, latency
// measured in cycles from the accept edge, handshake/flush/reset checks.
module tb_divider;

  logic        clk = 1'b0;
  logic        rst, div_valid, div_ready, divw, div_signed, flush;
  logic        out_valid, out_ready;
  logic [63:0] dividend, divisor, quotient, remainder;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
  } exp_t;
  exp_t sb[$];

  divider dut (
    .clk(clk), .rst(rst), .div_valid(div_valid), .div_ready(div_ready),
    .divw(divw), .div_signed(div_signed), .dividend(dividend), .divisor(divisor),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Present one request; returns in the cycle after the accept edge.
  task automatic issue(input logic [63:0] a, input logic [63:0] b,
                       input logic sg, input logic w);
    @(negedge clk);
    dividend = a; divisor = b; div_signed = sg; divw = w; div_valid = 1'b1;
    check("ready_before_accept", {63'd0, div_ready}, 64'd1);
    @(posedge clk);
    #1;
    div_valid  = 1'b0;
    dividend   = {$urandom, $urandom};
    divisor    = {$urandom, $urandom};
    div_signed = ~sg;
    divw       = ~w;
  endtask

  // Counts cycles from the accept edge until out_valid is seen, bounded.
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic sg, input logic w,
                        input logic [63:0] eq, input logic [63:0] er, input int elat);
    exp_t e;
    int   lat;
    sb.push_back('{q: eq, r: er, lat: elat});
    issue(a, b, sg, w);
    wait_result(lat);
    e = sb.pop_front();
    check({tag, "_lat"}, 64'(lat), 64'(e.lat));
    check({tag, "_q"}, quotient, e.q);
    check({tag, "_r"}, remainder, e.r);
    @(negedge clk);
    check({tag, "_released"}, {62'd0, out_valid, div_ready}, 64'b01);
  endtask

  initial begin
    exp_t e;
    int   lat;
    logic seen;

    rst = 1'b1; div_valid = 1'b0; divw = 1'b0; div_signed = 1'b0; flush = 1'b0;
    out_ready = 1'b1; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {63'd0, div_ready}, 64'd1);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_q", quotient, 64'd0);
    check("rst_r", remainder, 64'd0);
    rst = 1'b0;

    run_op("u100_7", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 65);
    run_op("s-7_2", -64'sd7, 64'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, '1, 65);
    run_op("s7_-2", 64'd7, -64'sd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65);
    run_op("w_ovf", 64'h0000_0000_8000_0000, '1, 1'b1, 1'b1,
           64'hFFFF_FFFF_8000_0000, 64'd0, 1);
    run_op("d_ovf", 64'h8000_0000_0000_0000, '1, 1'b1, 1'b0,
           64'h8000_0000_0000_0000, 64'd0, 1);
    run_op("u5_0", 64'd5, 64'd0, 1'b0, 1'b0, '1, 64'd5, 1);
    run_op("w_zero", 64'h0000_0000_8000_0005, 64'h0000_0001_0000_0000, 1'b0, 1'b1,
           '1, 64'hFFFF_FFFF_8000_0005, 1);
    run_op("w_s-7_2", 64'h1234_5678_FFFF_FFF9, 64'hAAAA_AAAA_0000_0002, 1'b1, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFD, '1, 33);
    run_op("w_u_half", 64'hDEAD_0000_FFFF_FFFF, 64'd2, 1'b0, 1'b1,
           64'h0000_0000_7FFF_FFFF, 64'd1, 33);
    run_op("w_u_sext", 64'h0000_0000_FFFF_FFF0, 64'd1, 1'b0, 1'b1,
           64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 33);
    run_op("u_big", '1, 64'h0000_0001_0000_0000, 1'b0, 1'b0,
           64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 65);

    // Backpressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    sb.push_back('{q: 64'd142, r: 64'd6, lat: 65});
    issue(64'd1000, 64'd7, 1'b0, 1'b0);
    wait_result(lat);
    e = sb.pop_front();
    check("bp_lat", 64'(lat), 64'(e.lat));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_valid", {62'd0, out_valid, div_ready}, 64'b10);
      check("bp_hold_q", quotient, e.q);
      check("bp_hold_r", remainder, e.r);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {62'd0, out_valid, div_ready}, 64'b01);

    // Flush during iteration 10 of a 64-bit op.
    issue(64'd123456789, 64'd11, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    check("fl_busy", {63'd0, div_ready}, 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    check("fl_idle", {62'd0, out_valid, div_ready}, 64'b01);
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("fl_no_result", {63'd0, seen}, 64'd0);
    run_op("after_fl", 64'd9, 64'd3, 1'b0, 1'b0, 64'd3, 64'd0, 65);

    // Reset mid-operation discards the result.
    issue(64'd77, 64'd5, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_state", {62'd0, out_valid, div_ready}, 64'b01);
    check("mid_rst_q", quotient, 64'd0);
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("mid_rst_no_result", {63'd0, seen}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
